// File: rtl/register_file.sv
// register_file: 8 x 16-bit general-purpose register file for the CPU datapath.
// Two combinational read ports (RS/RT) and one synchronous write port (RD).
// There is no handshake: RD, WriteData and RegWrite are sampled on the rising
// edge of Clock, and the read ports follow their indices with zero latency.
// R0 is an ordinary writable register, not a hardwired zero.
// There is no write-through bypass. A read of the index being written shows
// the old value until the capturing edge.

module register_file #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic [ADDR_WIDTH-1:0] RS,
    input  logic [ADDR_WIDTH-1:0] RT,
    input  logic [ADDR_WIDTH-1:0] RD,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] ReadRS,
    output logic [DATA_WIDTH-1:0] ReadRT,
    input  logic                  RegWrite,
    input  logic                  Clock,
    input  logic                  ResetN
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];

    // Next-state: hold every register, except replace R[RD] when the write is enabled.
    always_comb begin
        regs_d = regs_q;
        if (RegWrite) begin
            regs_d[RD] = WriteData;
        end
    end

    // Storage: asynchronous clear wins over a coincident write edge.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Combinational read ports. An unknown index propagates X to the output only.
    assign ReadRS = regs_q[RS];
    assign ReadRT = regs_q[RT];

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed scenarios plus randomized traffic, checked against
// a plain array model of eight 16-bit registers.

module tb_register_file;

    logic [2:0]  RS;
    logic [2:0]  RT;
    logic [2:0]  RD;
    logic [15:0] WriteData;
    logic [15:0] ReadRS;
    logic [15:0] ReadRT;
    logic        RegWrite;
    logic        Clock;
    logic        ResetN;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] model [8];

    register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
        .RS        (RS),
        .RT        (RT),
        .RD        (RD),
        .WriteData (WriteData),
        .ReadRS    (ReadRS),
        .ReadRT    (ReadRT),
        .RegWrite  (RegWrite),
        .Clock     (Clock),
        .ResetN    (ResetN)
    );

    // Clock: 10 ns period, rising edges at 5, 15, 25, ...
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance one rising edge, then step off it so reads and drives are away from the edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    endtask

    task automatic test_reset();
        ResetN = 1'b0;
        RegWrite = 1'b0;
        RD = 3'd0;
        WriteData = 16'h0000;
        #2;
        for (int i = 0; i < 8; i++) begin
            RS = 3'(i);
            RT = 3'(7 - i);
            #1;
            n_total++;
            if (ReadRS !== 16'h0000 || ReadRT !== 16'h0000)
                $display("FAIL reset_read rs=%0d rt=%0d got %h/%h want 0000/0000", i, 7 - i, ReadRS, ReadRT);
            else n_pass++;
        end
        @(negedge Clock);
        ResetN = 1'b1;
        clear_model();
        tick();
    endtask

    task automatic test_basic_writes();
        RD = 3'd0; WriteData = 16'd5; RegWrite = 1'b1;
        tick();
        RD = 3'd1; WriteData = 16'd7;
        tick();
        RegWrite = 1'b0;
        model[0] = 16'd5;
        model[1] = 16'd7;
        RS = 3'd0; RT = 3'd1;
        #1;
        n_total++;
        if (ReadRS !== 16'd5 || ReadRT !== 16'd7)
            $display("FAIL basic_writes got %h/%h want 0005/0007", ReadRS, ReadRT);
        else n_pass++;
    endtask

    task automatic test_write_disable();
        RegWrite = 1'b0; RD = 3'd2; WriteData = 16'hBEEF;
        tick();
        RS = 3'd2; RT = 3'd2;
        #1;
        n_total++;
        if (ReadRS !== 16'h0000 || ReadRT !== 16'h0000)
            $display("FAIL write_disable got %h/%h want 0000/0000", ReadRS, ReadRT);
        else n_pass++;
    endtask

    task automatic test_full_sweep();
        RegWrite = 1'b1;
        for (int i = 0; i < 8; i++) begin
            RD = 3'(i);
            WriteData = 16'(16'h1111 * (i + 1));
            tick();
            model[i] = 16'(16'h1111 * (i + 1));
        end
        RegWrite = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                RS = 3'(i);
                RT = 3'(j);
                #1;
                n_total++;
                if (ReadRS !== 16'(16'h1111 * (i + 1)) || ReadRT !== 16'(16'h1111 * (j + 1)))
                    $display("FAIL full_sweep rs=%0d rt=%0d got %h/%h want %h/%h", i, j, ReadRS, ReadRT,
                             16'(16'h1111 * (i + 1)), 16'(16'h1111 * (j + 1)));
                else n_pass++;
            end
        end
        tick();
    endtask

    task automatic test_async_reset_pulse();
        RegWrite = 1'b0;
        @(negedge Clock);
        #1;
        ResetN = 1'b0;
        #1;
        RS = 3'd0; RT = 3'd7;
        #1;
        n_total++;
        if (ReadRS !== 16'h0000 || ReadRT !== 16'h0000)
            $display("FAIL reset_pulse_immediate got %h/%h want 0000/0000", ReadRS, ReadRT);
        else n_pass++;
        ResetN = 1'b1;
        clear_model();
        for (int i = 0; i < 8; i++) begin
            RS = 3'(i);
            RT = 3'(i);
            #1;
            n_total++;
            if (ReadRS !== 16'h0000 || ReadRT !== 16'h0000)
                $display("FAIL reset_pulse_sweep idx=%0d got %h/%h want 0000/0000", i, ReadRS, ReadRT);
            else n_pass++;
        end
        tick();
    endtask

    task automatic test_same_cycle();
        RS = 3'd3; RT = 3'd3; RD = 3'd3; WriteData = 16'hA5A5; RegWrite = 1'b1;
        #1;
        n_total++;
        if (ReadRS !== 16'h0000)
            $display("FAIL same_cycle_before got %h want 0000", ReadRS);
        else n_pass++;
        tick();
        RegWrite = 1'b0;
        model[3] = 16'hA5A5;
        n_total++;
        if (ReadRS !== 16'hA5A5 || ReadRT !== 16'hA5A5)
            $display("FAIL same_cycle_after got %h/%h want a5a5/a5a5", ReadRS, ReadRT);
        else n_pass++;
    endtask

    task automatic test_reset_priority();
        RD = 3'd4; WriteData = 16'h1234; RegWrite = 1'b1;
        @(negedge Clock);
        ResetN = 1'b0;
        tick();
        RegWrite = 1'b0;
        clear_model();
        for (int i = 0; i < 8; i++) begin
            RS = 3'(i);
            RT = 3'(7 - i);
            #1;
            n_total++;
            if (ReadRS !== 16'h0000 || ReadRT !== 16'h0000)
                $display("FAIL reset_priority idx=%0d got %h/%h want 0000/0000", i, ReadRS, ReadRT);
            else n_pass++;
        end
        @(negedge Clock);
        ResetN = 1'b1;
        tick();
        RD = 3'd4; WriteData = 16'd9; RegWrite = 1'b1;
        tick();
        RegWrite = 1'b0;
        model[4] = 16'd9;
        RS = 3'd4; RT = 3'd5;
        #1;
        n_total++;
        if (ReadRS !== 16'd9 || ReadRT !== 16'h0000)
            $display("FAIL reset_release_write got %h/%h want 0009/0000", ReadRS, ReadRT);
        else n_pass++;
    endtask

    // Random traffic with indices drawn from 0..15 to exercise modulo-8 truncation.
    task automatic test_random();
        int rs_i, rt_i, rd_i;
        logic we;
        logic [15:0] data;
        for (int n = 0; n < 300; n++) begin
            rs_i = int'($urandom_range(0, 15));
            rt_i = int'($urandom_range(0, 15));
            rd_i = ($urandom_range(0, 3) == 0) ? rs_i : int'($urandom_range(0, 15));
            we   = 1'($urandom_range(0, 1));
            data = 16'($urandom);
            RS = 3'(rs_i); RT = 3'(rt_i); RD = 3'(rd_i); WriteData = data; RegWrite = we;
            #1;
            n_total++;
            if (ReadRS !== model[rs_i % 8] || ReadRT !== model[rt_i % 8])
                $display("FAIL random_pre n=%0d rs=%0d rt=%0d got %h/%h want %h/%h", n, rs_i, rt_i,
                         ReadRS, ReadRT, model[rs_i % 8], model[rt_i % 8]);
            else n_pass++;
            tick();
            if (we) model[rd_i % 8] = data;
            n_total++;
            if (ReadRS !== model[rs_i % 8] || ReadRT !== model[rt_i % 8])
                $display("FAIL random_post n=%0d rs=%0d rt=%0d got %h/%h want %h/%h", n, rs_i, rt_i,
                         ReadRS, ReadRT, model[rs_i % 8], model[rt_i % 8]);
            else n_pass++;
        end
        RegWrite = 1'b0;
    endtask

    initial begin
        RS = 3'd0; RT = 3'd0; RD = 3'd0; WriteData = 16'h0000; RegWrite = 1'b0; ResetN = 1'b0;
        clear_model();
        test_reset();
        test_basic_writes();
        test_write_disable();
        test_full_sweep();
        test_async_reset_pulse();
        test_same_cycle();
        test_reset_priority();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
